// File: rtl/dram_mem.sv
// Byte-addressable little-endian data memory, 1-cycle registered reads.
// Memory contents power up as all zeros.
module dram_mem #(
   parameter int    ADDR_W    = 14,
   parameter int    DATA_W    = 32,
   parameter string INIT_FILE = "dram.hex"
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_ren,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic              in_wen,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [1:0]        in_size,
   output logic [DATA_W-1:0] out_rdata,
   output logic              out_rvalid,
   output logic              out_misalign
);

   localparam int DEPTH = 2**ADDR_W;

   logic [7:0]        mem_q [DEPTH];
   logic [1:0]        lane;
   logic              legal;
   logic [3:0]        byte_en;
   logic [DATA_W-1:0] rd_mask;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] wr_data;
   logic              do_wr;

   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              misalign_q, misalign_d;

   assign lane = in_addr[1:0];

   always_comb begin
      legal   = 1'b0;
      byte_en = 4'h0;
      rd_mask = '0;
      unique case (in_size)
         2'd0: begin
            legal   = 1'b1;
            byte_en = 4'h1 << lane;
            rd_mask = 32'h0000_00FF;
         end
         2'd1: begin
            legal   = ~in_addr[0];
            byte_en = 4'h3 << lane;
            rd_mask = 32'h0000_FFFF;
         end
         2'd2: begin
            legal   = (lane == 2'd0);
            byte_en = 4'hF;
            rd_mask = 32'hFFFF_FFFF;
         end
         default: begin
            legal   = 1'b0;
            byte_en = 4'h0;
            rd_mask = '0;
         end
      endcase
   end

   assign rd_word = {mem_q[{in_addr[ADDR_W-1:2], 2'd3}],
                     mem_q[{in_addr[ADDR_W-1:2], 2'd2}],
                     mem_q[{in_addr[ADDR_W-1:2], 2'd1}],
                     mem_q[{in_addr[ADDR_W-1:2], 2'd0}]};
   assign rd_val  = (rd_word >> {lane, 3'b000}) & rd_mask;
   assign wr_data = in_wdata << {lane, 3'b000};
   assign do_wr   = in_wen & legal;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] = 8'h00;
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (do_wr && byte_en[i])
            mem_q[{in_addr[ADDR_W-1:2], 2'(i)}] <= wr_data[8*i +: 8];
      end
   end

   always_comb begin
      rdata_d    = rdata_q;
      rvalid_d   = 1'b0;
      misalign_d = (in_ren | in_wen) & ~legal;
      if (in_ren) begin
         rvalid_d = 1'b1;
         rdata_d  = legal ? rd_val : '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         misalign_q <= misalign_d;
      end
   end

   assign out_rdata    = rdata_q;
   assign out_rvalid   = rvalid_q;
   assign out_misalign = misalign_q;

endmodule

// File: tb/tb_dram_mem.sv
// Directed self-checking bench for dram_mem.
module tb_dram_mem;

   logic        clock;
   logic        reset_n;
   logic        in_ren;
   logic [13:0] in_addr;
   logic        in_wen;
   logic [31:0] in_wdata;
   logic [1:0]  in_size;
   logic [31:0] out_rdata;
   logic        out_rvalid;
   logic        out_misalign;

   int n_tests;
   int n_fail;

   dram_mem dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .in_ren       (in_ren),
      .in_addr      (in_addr),
      .in_wen       (in_wen),
      .in_wdata     (in_wdata),
      .in_size      (in_size),
      .out_rdata    (out_rdata),
      .out_rvalid   (out_rvalid),
      .out_misalign (out_misalign)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic op(input logic r, input logic w, input logic [13:0] a,
                     input logic [1:0] s, input logic [31:0] d);
      @(negedge clock);
      in_ren   = r;
      in_wen   = w;
      in_addr  = a;
      in_size  = s;
      in_wdata = d;
      @(posedge clock);
      #1;
      in_ren = 1'b0;
      in_wen = 1'b0;
   endtask

   logic [13:0] baddr [4];
   logic [31:0] bexp  [4];

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      in_ren   = 1'b0;
      in_wen   = 1'b0;
      in_addr  = '0;
      in_size  = 2'd0;
      in_wdata = '0;

      repeat (3) @(posedge clock);
      #1;
      check("rst_rdata", out_rdata, 32'h0);
      check("rst_rvalid", {31'b0, out_rvalid}, 32'h0);
      check("rst_misalign", {31'b0, out_misalign}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;

      op(1, 0, 14'h0000, 2'd2, 32'h0);
      check("rd0_data", out_rdata, 32'h0);
      check("rd0_valid", {31'b0, out_rvalid}, 32'h1);
      check("rd0_mis", {31'b0, out_misalign}, 32'h0);

      op(0, 1, 14'h0010, 2'd2, 32'hDEADBEEF);
      check("wr_novalid", {31'b0, out_rvalid}, 32'h0);

      baddr = '{14'h0010, 14'h0011, 14'h0012, 14'h0013};
      bexp  = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
      for (int i = 0; i < 4; i++) begin
         op(1, 0, baddr[i], 2'd0, 32'h0);
         check($sformatf("byte_rd_%0d", i), out_rdata, bexp[i]);
      end
      op(1, 0, 14'h0012, 2'd1, 32'h0);
      check("half_rd_12", out_rdata, 32'h0000DEAD);

      op(0, 1, 14'h0020, 2'd2, 32'h11223344);
      op(0, 1, 14'h0021, 2'd0, 32'hFFFFFFAA);
      op(1, 0, 14'h0020, 2'd2, 32'h0);
      check("part_byte", out_rdata, 32'h1122AA44);
      op(0, 1, 14'h0022, 2'd1, 32'hFFFF5566);
      op(1, 0, 14'h0020, 2'd2, 32'h0);
      check("part_half", out_rdata, 32'h5566AA44);

      op(0, 0, 14'h0000, 2'd0, 32'h0);
      check("idle_hold", out_rdata, 32'h5566AA44);
      check("idle_valid", {31'b0, out_rvalid}, 32'h0);

      op(1, 0, 14'h0011, 2'd2, 32'h0);
      check("mis_rd_data", out_rdata, 32'h0);
      check("mis_rd_valid", {31'b0, out_rvalid}, 32'h1);
      check("mis_rd_flag", {31'b0, out_misalign}, 32'h1);
      op(0, 1, 14'h0013, 2'd2, 32'h55555555);
      check("mis_wr_flag", {31'b0, out_misalign}, 32'h1);
      op(0, 1, 14'h0011, 2'd1, 32'h00007777);
      check("mis_hw_flag", {31'b0, out_misalign}, 32'h1);
      op(1, 0, 14'h0010, 2'd2, 32'h0);
      check("mis_unchanged", out_rdata, 32'hDEADBEEF);
      check("mis_cleared", {31'b0, out_misalign}, 32'h0);
      op(1, 0, 14'h0020, 2'd3, 32'h0);
      check("sz3_flag", {31'b0, out_misalign}, 32'h1);
      check("sz3_data", out_rdata, 32'h0);
      op(0, 1, 14'h0020, 2'd3, 32'h99999999);
      op(1, 0, 14'h0020, 2'd2, 32'h0);
      check("sz3_nowrite", out_rdata, 32'h5566AA44);

      op(0, 1, 14'h0030, 2'd2, 32'h01020304);
      op(1, 1, 14'h0030, 2'd2, 32'hCAFEF00D);
      check("rbw_old", out_rdata, 32'h01020304);
      check("rbw_valid", {31'b0, out_rvalid}, 32'h1);
      op(1, 0, 14'h0030, 2'd2, 32'h0);
      check("rbw_new", out_rdata, 32'hCAFEF00D);

      op(0, 1, 14'h3FFC, 2'd2, 32'h89ABCDEF);
      op(1, 0, 14'h3FFC, 2'd2, 32'h0);
      check("top_word", out_rdata, 32'h89ABCDEF);
      op(1, 0, 14'h3FFF, 2'd0, 32'h0);
      check("top_byte", out_rdata, 32'h00000089);
      op(1, 0, 14'h3FFE, 2'd1, 32'h0);
      check("top_half", out_rdata, 32'h000089AB);

      op(1, 0, 14'h3FFC, 2'd2, 32'h0);
      check("pre_rst_valid", {31'b0, out_rvalid}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_data", out_rdata, 32'h0);
      check("arst_valid", {31'b0, out_rvalid}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      op(1, 0, 14'h3FFC, 2'd2, 32'h0);
      check("post_rst_mem", out_rdata, 32'h89ABCDEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
